mul_csa_pipe: RTL and testbench

MUL_CSA_PIPE -- requirements
Module: mul_csa_pipe

---
 rtl/mul_csa_pipe_pkg.sv | 40 ++++
 rtl/mul_csa_pipe_csa_3to2.sv | 15 +
 rtl/mul_csa_pipe.sv | 143 ++++++++++++++
 tb/tb_mul_csa_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_csa_pipe_pkg.sv
// Shared constants and Booth helpers for the two-stage carry-save multiplier.
package mul_csa_pipe_pkg;

  localparam int XLEN       = 32;
  localparam int PW         = 2 * XLEN;
  localparam int NPP        = 17;
  localparam int CSA_LEVELS = 6;

  typedef enum logic [2:0] {
    BSEL_ZERO = 3'd0,
    BSEL_POS1 = 3'd1,
    BSEL_POS2 = 3'd2,
    BSEL_NEG1 = 3'd3,
    BSEL_NEG2 = 3'd4
  } booth_sel_e;

  // Radix-4 Booth recoding of the triplet {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_sel_e booth_decode(input logic [2:0] trip);
    booth_sel_e sel;
    case (trip)
      3'b001, 3'b010: sel = BSEL_POS1;
      3'b011:         sel = BSEL_POS2;
      3'b100:         sel = BSEL_NEG2;
      3'b101, 3'b110: sel = BSEL_NEG1;
      default:        sel = BSEL_ZERO;
    endcase
    return sel;
  endfunction

  // Number of live vectors entering Wallace level lvl (17, 12, 8, 6, 4, 3, 2).
  function automatic int csa_level_cnt(input int lvl);
    int n;
    n = NPP;
    for (int i = 0; i < lvl; i++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

endpackage

// File: rtl/mul_csa_pipe_csa_3to2.sv
// One row of 3:2 carry-save compressors; carry is pre-shifted into its weight.
module csa_3to2 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = {((a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0])), 1'b0};

endmodule

// File: rtl/mul_csa_pipe.sv
// Two-stage multiplier: Booth partial products + Wallace tree, then a final adder.
// Valid/ready handshake on both sides with flush and synchronous reset.
module mul_csa_pipe
  import mul_csa_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mul_signed,
  input  logic [XLEN-1:0]   mul_src1,
  input  logic [XLEN-1:0]   mul_src2,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] out_prod
);

  logic [XLEN:0]   a_ext_s;
  logic [XLEN+1:0] b_ext_s;
  logic [PW-1:0]   a_pos_s;
  logic [PW-1:0]   a_neg_s;
  logic [PW-1:0]   tree_s [CSA_LEVELS+1][NPP];

  logic            s1_valid_r;
  logic [PW-1:0]   s1_sum_r;
  logic [PW-1:0]   s1_carry_r;
  logic            out_valid_r;
  logic [PW-1:0]   out_prod_r;
  logic            s2_load_s;
  logic            in_ready_s;
  logic            accept_s;

  // b is extended twice so the top Booth triplet sees a proper sign.
  assign a_ext_s = {mul_signed & mul_src1[XLEN-1], mul_src1};
  assign b_ext_s = {{2{mul_signed & mul_src2[XLEN-1]}}, mul_src2};
  assign a_pos_s = {{(PW-XLEN-1){a_ext_s[XLEN]}}, a_ext_s};
  assign a_neg_s = (~a_pos_s) + {{(PW-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    logic [2:0]    trip_s;
    booth_sel_e    sel_s;
    logic [PW-1:0] mag_s;

    if (i == 0) begin : g_first
      assign trip_s = {b_ext_s[1:0], 1'b0};
    end else begin : g_rest
      assign trip_s = b_ext_s[2*i+1 -: 3];
    end

    assign sel_s = booth_decode(trip_s);

    // Select the scaled multiplicand for this Booth digit.
    always_comb begin
      mag_s = {PW{1'b0}};
      case (sel_s)
        BSEL_POS1: mag_s = a_pos_s;
        BSEL_POS2: mag_s = a_pos_s << 1;
        BSEL_NEG1: mag_s = a_neg_s;
        BSEL_NEG2: mag_s = a_neg_s << 1;
        default:   mag_s = {PW{1'b0}};
      endcase
    end

    assign tree_s[0][i] = mag_s << (2 * i);
  end

  for (genvar l = 0; l < CSA_LEVELS; l++) begin : g_lvl
    localparam int N = csa_level_cnt(l);
    localparam int G = N / 3;
    localparam int R = N % 3;

    for (genvar g = 0; g < G; g++) begin : g_csa
      csa_3to2 #(.W(PW)) u_csa (
        .a     (tree_s[l][3*g]),
        .b     (tree_s[l][3*g+1]),
        .c     (tree_s[l][3*g+2]),
        .sum   (tree_s[l+1][2*g]),
        .carry (tree_s[l+1][2*g+1])
      );
    end
    for (genvar r = 0; r < R; r++) begin : g_pass
      assign tree_s[l+1][2*G+r] = tree_s[l][3*G+r];
    end
    for (genvar z = 2*G+R; z < NPP; z++) begin : g_zero
      assign tree_s[l+1][z] = {PW{1'b0}};
    end
  end

  assign s2_load_s  = !out_valid_r || out_ready;
  assign in_ready_s = !flush && (!s1_valid_r || s2_load_s);
  assign accept_s   = in_valid && in_ready_s;

  // Pipeline occupancy; reset beats flush, flush beats handshakes.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        s1_valid_r <= 1'b1;
      end else if (s2_load_s) begin
        s1_valid_r <= 1'b0;
      end else begin
        s1_valid_r <= s1_valid_r;
      end
      if (s2_load_s) begin
        out_valid_r <= s1_valid_r;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Carry-save pair captured on accept only.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      s1_sum_r   <= tree_s[CSA_LEVELS][0];
      s1_carry_r <= tree_s[CSA_LEVELS][1];
    end else begin
      s1_sum_r   <= s1_sum_r;
      s1_carry_r <= s1_carry_r;
    end
  end

  // Final carry-propagate add into the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_prod_r <= {PW{1'b0}};
    end else if (!flush && s2_load_s && s1_valid_r) begin
      out_prod_r <= s1_sum_r + s1_carry_r;
    end else begin
      out_prod_r <= out_prod_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_prod  = out_prod_r;

endmodule

// File: tb/tb_mul_csa_pipe.sv
// Scoreboard bench for mul_csa_pipe: expected products queued at accept, popped at transfer.
module tb_mul_csa_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        mul_signed;
  logic [31:0] mul_src1;
  logic [31:0] mul_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic        acc;
  logic        xfer;
  logic [63:0] got;
  logic [63:0] want;

  always #5 clk = ~clk;

  mul_csa_pipe #(.XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mul_signed (mul_signed),
    .mul_src1   (mul_src1),
    .mul_src2   (mul_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod)
  );

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ae;
    logic [63:0] be;
    ae = {{32{s & a[31]}}, a};
    be = {{32{s & b[31]}}, b};
    return ae * be;
  endfunction

  // Samples handshakes just before the edge, queues accepted work, then steps one clock.
  task automatic cycle();
    #1;
    acc  = in_valid & in_ready;
    xfer = out_valid & out_ready;
    got  = out_prod;
    if (acc) exp_q.push_back(ref_mul(mul_signed, mul_src1, mul_src2));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    mul_signed = 1'($urandom_range(0, 1));
    mul_src1   = $urandom;
    mul_src2   = $urandom;
    if ($urandom_range(0, 7) == 0) mul_src1 = 32'h8000_0000;
    if ($urandom_range(0, 7) == 0) mul_src2 = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    mul_signed = 1'b0; mul_src1 = 32'd0; mul_src2 = 32'd0;
    cycle();
    cycle();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_prod !== 64'h0) begin n_err++; $display("FAIL reset_out_prod: got %h want 0", out_prod); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic        s_t [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] a_t [5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h0000_0007};
    logic [31:0] b_t [5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFD};
    logic [63:0] p_t [5]  = '{64'h0000_0000_0000_0001, 64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000,
                              64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFEB};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mul_signed = s_t[i]; mul_src1 = a_t[i]; mul_src2 = b_t[i]; in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_lat1_valid: got %b want 0", i, out_valid); end
      cycle();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_lat2_valid: got %b want 1", i, out_valid); end
      n_vec++; if (out_prod !== p_t[i]) begin n_err++; $display("FAIL dir%0d_prod: got %h want %h", i, out_prod, p_t[i]); end
      cycle();
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int sent = 0, got_n = 0, gaps = 0, stalls = 0;
    out_ready = 1'b1;
    rand_ops();
    for (int c = 0; c < 200 && got_n < 100; c++) begin
      in_valid = (sent < 100);
      cycle();
      if (in_valid && !acc) stalls++;
      if (acc) begin sent++; rand_ops(); end
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL b2b_unexpected: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          n_vec++; if (got !== want) begin n_err++; $display("FAIL b2b_prod%0d: got %h want %h", got_n, got, want); end
        end
        got_n++;
      end else if (got_n > 0 && got_n < 100) begin
        gaps++;
      end
    end
    in_valid = 1'b0;
    n_vec++; if (got_n !== 100) begin n_err++; $display("FAIL b2b_count: got %0d want 100", got_n); end
    n_vec++; if (gaps !== 0) begin n_err++; $display("FAIL b2b_bubbles: got %0d want 0", gaps); end
    n_vec++; if (stalls !== 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
  endtask

  task automatic test_backpressure();
    int sent = 0, got_n = 0;
    logic acc2;
    exp_q.delete();
    out_ready = 1'b0; in_valid = 1'b1; mul_signed = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mul_src1 = 32'h0000_1234 + 32'(k); mul_src2 = 32'hFFFF_FF00 - 32'(k);
      cycle();
      if (acc) sent++;
      acc2 = acc;
    end
    n_vec++; if (sent !== 2) begin n_err++; $display("FAIL bp_accepts: got %0d want 2", sent); end
    n_vec++; if (acc2 !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop: got %b want 0", acc2); end
    n_vec++; if (exp_q.size() == 0 || out_prod !== exp_q[0]) begin
      n_err++; $display("FAIL bp_hold_prod: got %h want first queued product", out_prod);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (xfer) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL bp_duplicate: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          n_vec++; if (got !== want) begin n_err++; $display("FAIL bp_prod%0d: got %h want %h", got_n, got, want); end
        end
        got_n++;
      end
    end
    n_vec++; if (got_n !== 2) begin n_err++; $display("FAIL bp_drain_count: got %0d want 2", got_n); end
  endtask

  task automatic test_flush();
    int seen = 0;
    exp_q.delete();
    out_ready = 1'b0; in_valid = 1'b1; mul_signed = 1'b0;
    mul_src1 = 32'd11; mul_src2 = 32'd13; cycle();
    mul_src1 = 32'd17; mul_src2 = 32'd19; cycle();
    flush = 1'b1;
    cycle();
    n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", acc); end
    flush = 1'b0; in_valid = 1'b0; exp_q.delete();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin cycle(); if (xfer) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL flush_stale_output: got %0d want 0", seen); end
    exp_q.delete();
    in_valid = 1'b1; mul_src1 = 32'd3; mul_src2 = 32'd5;
    cycle();
    in_valid = 1'b0; seen = 0;
    for (int c = 0; c < 4 && seen == 0; c++) begin
      cycle();
      if (xfer) begin
        seen = 1;
        n_vec++; if (got !== 64'h0000_0000_0000_000F) begin n_err++; $display("FAIL flush_next_prod: got %h want %h", got, 64'hF); end
      end
    end
    if (seen == 0) begin n_vec++; n_err++; $display("FAIL flush_next_timeout: got none want %h", 64'hF); end
    exp_q.delete();
    // flush coinciding with a consumer transfer: the transferred product still counts
    in_valid = 1'b1; mul_signed = 1'b1; mul_src1 = 32'hFFFF_FFF9; mul_src2 = 32'd6;
    cycle();
    in_valid = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    n_vec++; if (xfer !== 1'b1 || got !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      n_err++; $display("FAIL flush_xfer: got %b/%h want 1/%h", xfer, got, 64'hFFFF_FFFF_FFFF_FFD6);
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_xfer_after: got %b want 0", out_valid); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b1; in_valid = 1'b1; mul_signed = 1'b0; mul_src1 = 32'd9; mul_src2 = 32'd9;
    cycle();
    in_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0; exp_q.delete();
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 4; c++) begin cycle(); if (out_valid) seen++; end
    n_vec++; if (seen !== 0) begin n_err++; $display("FAIL rstmid_out_valid: got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
